// File: rtl/s84_pkg.sv
// Shared definitions for the s84 fault-campaign controller: FSM state
// encoding, fault-type encodings, fault-space constants and the mapping
// from (location, fault type) to a detect_mask bit.
package s84_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DRV_G,
    ST_WAIT_G,
    ST_SMP_G,
    ST_DRV_F,
    ST_WAIT_F,
    ST_SMP_F,
    ST_ADV,
    ST_FIN
  } s84_camp_state_t;

  localparam int unsigned NUM_FAULT_TYPES = 3;
  localparam int unsigned NUM_FAULTS      = 24;

  // f_type encodings understood by s84
  localparam logic [1:0] FT_NONE = 2'd0;
  localparam logic [1:0] FT_SA0  = 2'd1;
  localparam logic [1:0] FT_SA1  = 2'd2;
  localparam logic [1:0] FT_FLIP = 2'd3;

  // detect_mask bit for a fault: loc*3 + (type-1)
  function automatic logic [4:0] fault_idx(input logic [2:0] loc, input logic [1:0] ftype);
    return ({2'b00, loc} * 5'd3) + {3'b000, ftype} - 5'd1;
  endfunction

endpackage

// File: rtl/s84_fault_campaign_if.sv
// Bus between the campaign controller and the s84 datapath. The controller
// (master) drives the operand/fault-select vector and reads Y/Z back; the
// datapath (slave) does the opposite.
interface s84_fault_campaign_if;
  logic [7:0] dut_a;
  logic [3:0] dut_b;
  logic       dut_op;
  logic [2:0] dut_floc;
  logic [1:0] dut_ftype;
  logic [7:0] dut_y;
  logic [3:0] dut_z;

  modport master (
    output dut_a, dut_b, dut_op, dut_floc, dut_ftype,
    input  dut_y, dut_z
  );

  modport slave (
    input  dut_a, dut_b, dut_op, dut_floc, dut_ftype,
    output dut_y, dut_z
  );
endinterface

// File: rtl/s84_fault_iter.sv
// Nested b/type/loc counter for the fault campaign. b runs 0..15 innermost,
// fault type 1..3 next, location 0..NUM_LOC-1 outermost. skip abandons the
// remaining b values of the current fault. last flags the final fault.
module s84_fault_iter
  import s84_pkg::*;
#(
  parameter int unsigned NUM_LOC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       advance,
  input  logic       skip,
  output logic [3:0] b,
  output logic [1:0] ftype,
  output logic [2:0] loc,
  output logic       last
);

  logic [3:0] b_q,    b_d;
  logic [1:0] type_q, type_d;
  logic [2:0] loc_q,  loc_d;

  // Next-count logic: clear restarts the sweep, advance steps it
  always_comb begin
    // NOTE: every _d starts from its _q so no branch can infer a latch.
    b_d    = b_q;
    type_d = type_q;
    loc_d  = loc_q;
    if (clear) begin
      b_d    = 4'd0;
      type_d = FT_SA0;
      loc_d  = 3'd0;
    end else if (advance) begin
      if (skip || (b_q == 4'hF)) begin
        b_d = 4'd0;
        if (type_q == 2'(NUM_FAULT_TYPES)) begin
          type_d = FT_SA0;
          loc_d  = loc_q + 3'd1;
        end else begin
          type_d = type_q + 2'd1;
        end
      end else begin
        b_d = b_q + 4'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q    <= 4'd0;
      type_q <= 2'd0;
      loc_q  <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      b_q    <= b_d;
      type_q <= type_d;
      loc_q  <= loc_d;
    end
  end

  assign b     = b_q;
  assign ftype = type_q;
  assign loc   = loc_q;
  assign last  = (loc_q == 3'(NUM_LOC - 1)) && (type_q == 2'(NUM_FAULT_TYPES));

endmodule

// File: rtl/s84_fault_campaign.sv
// Fault-campaign controller for the s84 datapath. For each fault it sweeps
// B over 0..15, captures the fault-free Y/Z, re-applies the vector with the
// fault enabled and flags the fault as detected on any difference.
// Optional feature macro: S84_CAMPAIGN_EARLY_EXIT_EN -- when defined, the
// rest of a fault's B sweep is skipped once that fault has been detected.
module s84_fault_campaign
  import s84_pkg::*;
#(
  parameter int unsigned SETTLE  = 1,
  parameter int unsigned NUM_LOC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            a_val,
  input  logic                  op_sel,
  s84_fault_campaign_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [NUM_FAULTS-1:0] detect_mask,
  output logic [4:0]            detect_count
);

  localparam logic [3:0] WAIT_INIT = 4'(SETTLE - 1);

  s84_camp_state_t       state_q, state_d;
  logic [7:0]            a_q, a_d;
  logic                  op_q, op_d;
  logic [7:0]            gold_y_q, gold_y_d;
  logic [3:0]            gold_z_q, gold_z_d;
  logic [3:0]            wait_q, wait_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [NUM_FAULTS-1:0] mask_q, mask_d;
  logic [4:0]            count_q, count_d;
  logic [7:0]            dut_a_q, dut_a_d;
  logic [3:0]            dut_b_q, dut_b_d;
  logic                  dut_op_q, dut_op_d;
  logic [2:0]            dut_floc_q, dut_floc_d;
  logic [1:0]            dut_ftype_q, dut_ftype_d;
`ifdef S84_CAMPAIGN_EARLY_EXIT_EN
  logic                  hit_q, hit_d;
`endif

  logic       it_clear, it_adv, it_skip, it_last;
  logic [3:0] it_b;
  logic [1:0] it_type;
  logic [2:0] it_loc;
  logic       mismatch;
  logic       fin;
  logic [4:0] idx;

  s84_fault_iter #(.NUM_LOC(NUM_LOC)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (it_clear),
    .advance (it_adv),
    .skip    (it_skip),
    .b       (it_b),
    .ftype   (it_type),
    .loc     (it_loc),
    .last    (it_last)
  );

  // Campaign FSM next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    op_d        = op_q;
    gold_y_d    = gold_y_q;
    gold_z_d    = gold_z_q;
    wait_d      = wait_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    mask_d      = mask_q;
    count_d     = count_q;
    dut_a_d     = dut_a_q;
    dut_b_d     = dut_b_q;
    dut_op_d    = dut_op_q;
    dut_floc_d  = dut_floc_q;
    dut_ftype_d = dut_ftype_q;
`ifdef S84_CAMPAIGN_EARLY_EXIT_EN
    hit_d       = hit_q;
`endif
    it_clear    = 1'b0;
    it_adv      = 1'b0;
    it_skip     = 1'b0;
    fin         = 1'b0;
    idx         = fault_idx(it_loc, it_type);
    mismatch    = (bus.dut_y != gold_y_q) || (bus.dut_z != gold_z_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d  = '0;
          count_d = 5'd0;
          err_d   = 1'b0;
          if (a_val == 8'd0) begin
            // A=0 would make s84 divide by zero: abort without driving
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            a_d      = a_val;
            op_d     = op_sel;
            busy_d   = 1'b1;
            it_clear = 1'b1;
            state_d  = ST_DRV_G;
          end
        end
      end
      ST_DRV_G: begin
        dut_a_d     = a_q;
        dut_b_d     = it_b;
        dut_op_d    = op_q;
        dut_floc_d  = it_loc;
        dut_ftype_d = FT_NONE;
        wait_d      = WAIT_INIT;
        state_d     = (SETTLE > 1) ? ST_WAIT_G : ST_SMP_G;
      end
      ST_WAIT_G: begin
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) state_d = ST_SMP_G;
      end
      ST_SMP_G: begin
        gold_y_d = bus.dut_y;
        gold_z_d = bus.dut_z;
        state_d  = ST_DRV_F;
      end
      ST_DRV_F: begin
        dut_ftype_d = it_type;
        wait_d      = WAIT_INIT;
        state_d     = (SETTLE > 1) ? ST_WAIT_F : ST_SMP_F;
      end
      ST_WAIT_F: begin
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) state_d = ST_SMP_F;
      end
      ST_SMP_F: begin
`ifdef S84_CAMPAIGN_EARLY_EXIT_EN
        hit_d = mismatch;
`endif
        if (mismatch && !mask_q[idx]) begin
          mask_d[idx] = 1'b1;
          count_d     = count_q + 5'd1;
        end
        state_d = ST_ADV;
      end
      ST_ADV: begin
        it_adv = 1'b1;
`ifdef S84_CAMPAIGN_EARLY_EXIT_EN
        it_skip = hit_q;
        fin     = it_last && (hit_q || (it_b == 4'hF));
`else
        fin     = it_last && (it_b == 4'hF);
`endif
        if (fin) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          state_d = ST_DRV_G;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Campaign registers; reset clears everything including an in-flight sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= 8'd0;
      op_q        <= 1'b0;
      gold_y_q    <= 8'd0;
      gold_z_q    <= 4'd0;
      wait_q      <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mask_q      <= '0;
      count_q     <= 5'd0;
      dut_a_q     <= 8'd0;
      dut_b_q     <= 4'd0;
      dut_op_q    <= 1'b0;
      dut_floc_q  <= 3'd0;
      dut_ftype_q <= 2'd0;
`ifdef S84_CAMPAIGN_EARLY_EXIT_EN
      hit_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      op_q        <= op_d;
      gold_y_q    <= gold_y_d;
      gold_z_q    <= gold_z_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      dut_a_q     <= dut_a_d;
      dut_b_q     <= dut_b_d;
      dut_op_q    <= dut_op_d;
      dut_floc_q  <= dut_floc_d;
      dut_ftype_q <= dut_ftype_d;
`ifdef S84_CAMPAIGN_EARLY_EXIT_EN
      hit_q       <= hit_d;
`endif
    end
  end

  assign bus.dut_a     = dut_a_q;
  assign bus.dut_b     = dut_b_q;
  assign bus.dut_op    = dut_op_q;
  assign bus.dut_floc  = dut_floc_q;
  assign bus.dut_ftype = dut_ftype_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign detect_mask   = mask_q;
  assign detect_count  = count_q;

endmodule

// File: tb/tb_s84_fault_campaign.sv
// Self-checking bench for s84_fault_campaign. A behavioural s84 model closes
// the loop: op=0 computes (B*B with the selected fault applied to bit f_loc)
// mod A, op=1 returns the two's complement of A and ignores faults. Expected
// campaign results are queued when a campaign is launched and compared when
// done pulses.
module tb_s84_fault_campaign;
  import s84_pkg::*;

  localparam int SETTLE    = 1;
  localparam int NUM_LOC   = 8;
  localparam int VEC_CYC   = 2 * (SETTLE + 1) + 1;
  localparam int FULL_BUSY = NUM_LOC * 3 * 16 * VEC_CYC;

  typedef struct {
    logic [23:0] mask;
    logic [4:0]  count;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a_val;
  logic        op_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic [23:0] detect_mask;
  logic [4:0]  detect_count;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  s84_fault_campaign_if bus ();

  s84_fault_campaign #(.SETTLE(SETTLE), .NUM_LOC(NUM_LOC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .a_val        (a_val),
    .op_sel       (op_sel),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .detect_mask  (detect_mask),
    .detect_count (detect_count)
  );

  always #5 clk = ~clk;

  // Behavioural s84 with fault injection on the square's bits
  logic [7:0] m_c;
  always_comb begin
    m_c = {4'b0, bus.dut_b} * {4'b0, bus.dut_b};
    case (bus.dut_ftype)
      FT_SA0:  m_c[bus.dut_floc] = 1'b0;
      FT_SA1:  m_c[bus.dut_floc] = 1'b1;
      FT_FLIP: m_c[bus.dut_floc] = ~m_c[bus.dut_floc];
      default: m_c = m_c;
    endcase
    if (bus.dut_op) begin
      bus.dut_y = ~bus.dut_a + 8'd1;
      bus.dut_z = bus.dut_b;
    end else begin
      bus.dut_y = (bus.dut_a == 8'd0) ? 8'd0 : (m_c % bus.dut_a);
      bus.dut_z = bus.dut_y[7:4] ^ bus.dut_y[3:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one campaign, wait (bounded) for done, then score it
  task automatic run_campaign(input string tag, input logic [7:0] a, input logic op,
                              input logic [23:0] emask, input logic [4:0] ecount,
                              input logic eerr, input bit poke,
                              output int busy_cycles, output int latency);
    exp_t e;
    bit   seen;
    e.mask  = emask;
    e.count = ecount;
    e.err   = eerr;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; a_val = a; op_sel = op;
    @(negedge clk);
    start = 1'b0; a_val = 8'h5A; op_sel = ~op;
    busy_cycles = 0;
    latency     = -1;
    seen        = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        seen    = 1'b1;
        latency = i;
        break;
      end
      if (busy) busy_cycles++;
      if (poke && i == 100) begin
        start = 1'b1; a_val = 8'hFF; op_sel = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " done seen"}, 32'(seen), 1);
    e = sb_q.pop_front();
    if (seen) begin
      check({tag, " mask"},  32'(detect_mask),  32'(e.mask));
      check({tag, " count"}, 32'(detect_count), 32'(e.count));
      check({tag, " err"},   32'(err),          32'(e.err));
      check({tag, " busy low at done"}, 32'(busy), 0);
    end
  endtask

  initial begin
    int  bc, lat;
    bit  found, seen_done;

    // Reset state
    rst_n = 1'b0; start = 1'b0; a_val = 8'd0; op_sel = 1'b0;
    #1;
    check("rst busy",  32'(busy), 0);
    check("rst done",  32'(done), 0);
    check("rst err",   32'(err), 0);
    check("rst mask",  32'(detect_mask), 0);
    check("rst count", 32'(detect_count), 0);
    check("rst dut_a", 32'(bus.dut_a), 0);
    check("rst dut_b", 32'(bus.dut_b), 0);
    check("rst dut_ftype", 32'(bus.dut_ftype), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // A=0xFF square path: everything but stuck-at-0 on bit 1 is visible
    run_campaign("ff", 8'hFF, 1'b0, 24'hFFFFF7, 5'd23, 1'b0, 1'b0, bc, lat);
`ifdef S84_CAMPAIGN_EARLY_EXIT_EN
    check("ff early exit shorter", 32'(bc < FULL_BUSY), 1);
`else
    check("ff busy cycles", 32'(bc), 32'(FULL_BUSY));
`endif

    // A=1: every Y is 0; a mid-campaign start must be ignored
    run_campaign("a1", 8'h01, 1'b0, 24'h0, 5'd0, 1'b0, 1'b1, bc, lat);
    check("a1 busy cycles", 32'(bc), 32'(FULL_BUSY));

    // op=1 path ignores faults; fixed runtime in every build
    run_campaign("ca2", 8'h20, 1'b1, 24'h0, 5'd0, 1'b0, 1'b0, bc, lat);
    check("ca2 busy cycles", 32'(bc), 32'(FULL_BUSY));
    check("ca2 hold dut_a", 32'(bus.dut_a), 32'h20);
    check("ca2 hold dut_b", 32'(bus.dut_b), 15);
    check("ca2 hold dut_op", 32'(bus.dut_op), 1);
    check("ca2 hold dut_floc", 32'(bus.dut_floc), NUM_LOC - 1);
    check("ca2 hold dut_ftype", 32'(bus.dut_ftype), 32'(FT_FLIP));

    // A=0 guard: immediate done with err, nothing driven
    run_campaign("a0", 8'h00, 1'b0, 24'h0, 5'd0, 1'b1, 1'b0, bc, lat);
    check("a0 done latency", 32'(lat), 0);
    check("a0 busy cycles", 32'(bc), 0);
    check("a0 dut_a untouched", 32'(bus.dut_a), 32'h20);
    check("a0 dut_ftype untouched", 32'(bus.dut_ftype), 32'(FT_FLIP));
    repeat (3) @(negedge clk);
    check("a0 err held", 32'(err), 1);
    check("a0 done one cycle", 32'(done), 0);

    // Asynchronous reset in the middle of location 3
    @(negedge clk);
    start = 1'b1; a_val = 8'hFF; op_sel = 1'b0;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (bus.dut_floc == 3'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mid reach loc 3", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst busy",  32'(busy), 0);
    check("mid rst done",  32'(done), 0);
    check("mid rst mask",  32'(detect_mask), 0);
    check("mid rst count", 32'(detect_count), 0);
    check("mid rst dut_floc", 32'(bus.dut_floc), 0);
    check("mid rst dut_a", 32'(bus.dut_a), 0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      if (done || busy) seen_done = 1'b1;
    end
    check("mid rst no done", 32'(seen_done), 0);

    // Restart after the abort completes normally
    run_campaign("restart", 8'hFF, 1'b0, 24'hFFFFF7, 5'd23, 1'b0, 1'b0, bc, lat);
    check("scoreboard drained", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
